// File: rtl/tsc_multicycle_core.sv
// tsc_multicycle_core: multi-cycle TSC CPU (FETCH/DECODE/EXEC/WB/HALT) with a
// req/ready instruction port.
// Ports: clk, reset (sync, high), cpu_enable, wwd_enable, register_selection,
//   i_req/i_addr/i_ready/i_data fetch port, num_inst, output_port,
//   PC_below8bit, wwd_valid, halted.
module tsc_multicycle_core #(
    parameter int WORD_SIZE = 16,
    parameter int PC_SIZE = 16,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_enable,
    input  logic                 wwd_enable,
    input  logic [1:0]           register_selection,
    output logic                 i_req,
    output logic [PC_SIZE-1:0]   i_addr,
    input  logic                 i_ready,
    input  logic [15:0]          i_data,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic [WORD_SIZE-1:0] output_port,
    output logic [7:0]           PC_below8bit,
    output logic                 wwd_valid,
    output logic                 halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t state, next;

    logic [15:0]          ir;
    logic [PC_SIZE-1:0]   pc, npc;
    logic [WORD_SIZE-1:0] regs [4];
    logic [WORD_SIZE-1:0] a, b, res;
    logic [1:0]           dst;
    logic                 wr, wwd_q;

    logic [3:0]  op;
    logic [1:0]  rs, rt, rd;
    logic [5:0]  func;
    logic [7:0]  imm;
    logic [11:0] target;
    logic        is_wwd, is_hlt;

    assign op     = ir[15:12];
    assign rs     = ir[11:10];
    assign rt     = ir[9:8];
    assign rd     = ir[7:6];
    assign func   = ir[5:0];
    assign imm    = ir[7:0];
    assign target = ir[11:0];
    assign is_wwd = (op == 4'd15) && (func == 6'd28);
    assign is_hlt = (op == 4'd15) && (func == 6'd29);

    assign i_req        = (state == FETCH) && cpu_enable && !reset;
    assign i_addr       = pc;
    assign PC_below8bit = pc[7:0];
    assign halted       = (state == HALT);
    // a pulse left over from WB is masked if the core stalls right after
    assign wwd_valid    = wwd_q && cpu_enable;

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else if (cpu_enable)
            state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            FETCH:   if (i_req && i_ready) next = DECODE;
            DECODE:  next = EXEC;
            EXEC:    next = WB;
            WB:      next = is_hlt ? HALT : FETCH;
            HALT:    next = HALT;
            default: next = FETCH;
        endcase
    end

    logic [WORD_SIZE-1:0] sext, ex_res;
    logic [PC_SIZE-1:0]   pc_inc, br_off, ex_npc;
    logic [1:0]           ex_dst;
    logic                 ex_wr, taken;

    assign sext   = {{(WORD_SIZE-8){imm[7]}}, imm};
    assign br_off = {{(PC_SIZE-8){imm[7]}}, imm};
    assign pc_inc = pc + PC_SIZE'(1);

    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            op == 4'd0: taken = (a != b);
            op == 4'd1: taken = (a == b);
            op == 4'd2: taken = !a[WORD_SIZE-1] && (a != '0);
            op == 4'd3: taken = a[WORD_SIZE-1];
            default:    taken = 1'b0;
        endcase
    end

    always_comb begin
        ex_res = '0;
        ex_wr  = 1'b0;
        ex_dst = rd;
        ex_npc = pc_inc;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                if (taken) ex_npc = pc_inc + br_off;
            end
            4'd4: begin
                ex_wr  = 1'b1;
                ex_dst = rt;
                ex_res = a + sext;
            end
            4'd5: begin
                ex_wr  = 1'b1;
                ex_dst = rt;
                ex_res = a | WORD_SIZE'(imm);
            end
            4'd6: begin
                ex_wr  = 1'b1;
                ex_dst = rt;
                ex_res = WORD_SIZE'({imm, 8'h00});
            end
            4'd9: begin
                // jumps keep the current page, not the page of PC+1
                ex_npc = pc;
                ex_npc[11:0] = target;
            end
            4'd10: begin
                ex_npc = pc;
                ex_npc[11:0] = target;
                ex_wr  = 1'b1;
                ex_dst = 2'd2;
                ex_res = WORD_SIZE'(pc_inc);
            end
            4'd15: begin
                ex_wr = 1'b1;
                case (func)
                    6'd0:  ex_res = a + b;
                    6'd1:  ex_res = a - b;
                    6'd2:  ex_res = a & b;
                    6'd3:  ex_res = a | b;
                    6'd4:  ex_res = ~a;
                    6'd5:  ex_res = ~a + WORD_SIZE'(1);
                    6'd6:  ex_res = a << 1;
                    6'd7:  ex_res = WORD_SIZE'($signed(a) >>> 1);
                    6'd25: begin
                        ex_wr  = 1'b0;
                        ex_npc = PC_SIZE'(a);
                    end
                    6'd26: begin
                        ex_dst = 2'd2;
                        ex_res = WORD_SIZE'(pc_inc);
                        ex_npc = PC_SIZE'(a);
                    end
                    default: ex_wr = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            res         <= '0;
            npc         <= RESET_PC;
            dst         <= '0;
            wr          <= 1'b0;
            wwd_q       <= 1'b0;
            num_inst    <= '0;
            output_port <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            wwd_q <= 1'b0;
            if (cpu_enable) begin
                if (!wwd_enable) output_port <= regs[register_selection];
                unique case (state)
                    FETCH: if (i_ready) ir <= i_data;
                    DECODE: begin
                        a <= regs[rs];
                        b <= regs[rt];
                    end
                    EXEC: begin
                        res <= ex_res;
                        npc <= ex_npc;
                        dst <= ex_dst;
                        wr  <= ex_wr;
                    end
                    WB: begin
                        if (wr) regs[dst] <= res;
                        pc       <= npc;
                        num_inst <= num_inst + WORD_SIZE'(1);
                        if (is_wwd && wwd_enable) begin
                            output_port <= a;
                            wwd_q       <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/tsc_multicycle_core.md
# tsc_multicycle_core

Parametrised multi-cycle successor of the single-cycle TSC CPU. It executes the full TSC integer subset:
- R-type ALU ops, ADI/ORI/LHI
- branches, JMP/JAL/JPR/JRL, WWD, HLT

It fetches over a req/ready instruction port instead of an internal ROM. It sits between the instruction memory and the board output logic, driving `output_port`, `PC_below8bit` and the simulation counter `num_inst`.

## Interface
- `WORD_SIZE`, default 16: data/register width, must be ≥16.
- `PC_SIZE`, default 16: PC and `i_addr` width, must be ≥12.
- `RESET_PC`, default 0: PC value after reset.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `cpu_enable`  in  1  when 0 the FSM, PC, registers and counters hold.
- `wwd_enable`  in  1  when 1, WWD updates `output_port`; when 0, `output_port` shows the register picked by `register_selection`.
- `register_selection`  in  2  register index shown while `wwd_enable`=0.
- `i_req`  out  1  instruction fetch request.
- `i_addr`  out  PC_SIZE  fetch address, equal to PC.
- `i_ready`  in  1  `i_data` valid; sampled only while `i_req`=1.
- `i_data`  in  16  instruction word.
- `num_inst`  out  WORD_SIZE  retired-instruction count.
- `output_port`  out  WORD_SIZE  WWD or selected-register value.
- `PC_below8bit`  out  8  PC[7:0].
- `wwd_valid`  out  1  one-cycle pulse when WWD writes `output_port`.
- `halted`  out  1  core is in HALT.

## Operation
- **Encoding**
  - op[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0], imm[7:0], target[11:0].
  - Immediates are sign-extended to WORD_SIZE, except ORI, which is zero-extended.
  - LHI writes {imm, 8'h00} zero-extended into rt.
- **Opcodes**
  - 0/1/2/3 = BNE/BEQ/BGZ/BLZ; branch target PC+1+sext(imm).
  - 4 = ADI, 5 = ORI, 6 = LHI (dest rt).
  - 9 = JMP, 10 = JAL; both set PC = {PC[PC_SIZE-1:12], target}. JAL also writes PC+1 to $2.
- **Opcode 15 (func)**
  - 0–7 = ADD/SUB/AND/ORR/NOT/TCP/SHL/SHR; dest rd, single-operand ops use rs. SHR is arithmetic; SHL/SHR shift by 1.
  - 25 = JPR: PC = rs[PC_SIZE-1:0].
  - 26 = JRL: PC = rs and $2 = PC+1.
  - 28 = WWD, 29 = HLT.
- **Branch conditions**
  - BNE/BEQ compare rs with rt.
  - BGZ: rs > 0 signed. BLZ: rs < 0 signed.
- **Undefined opcode or func:** NOP; PC+1 and still counted.
- **Register file:** 4×WORD_SIZE, cleared by reset. It is written only in WB.
- **Arithmetic:** modulo 2^WORD_SIZE. PC arithmetic is modulo 2^PC_SIZE.
- **FSM states:** FETCH, DECODE, EXEC, WB, HALT.
  - FETCH → DECODE on `i_req`&`i_ready`; IR ← `i_data`.
  - DECODE → EXEC: operands latched.
  - EXEC → WB: result and next PC computed.
  - WB → FETCH: register write, PC update, `num_inst`+1. HLT goes WB → HALT instead.
  - HALT is left only by reset.
- **`cpu_enable`=0:** state, PC, registers, `num_inst` and `output_port` hold. `i_req`=0 and `wwd_valid`=0. The memory must tolerate a withdrawn request.
- **`output_port`**
  - WWD in WB with `wwd_enable`=1: `output_port` ← rs and `wwd_valid`=1.
  - With `wwd_enable`=0, every enabled cycle: `output_port` ← reg[`register_selection`]. WWD is then retired without updating the port.
- **Wrap-around:** `num_inst` wraps from 2^WORD_SIZE−1 to 0. PC wraps the same way at 2^PC_SIZE.

## Timing
- **Reset values:** `i_req`=0, `i_addr`=PC=RESET_PC, `num_inst`=0, `output_port`=0, `wwd_valid`=0, `halted`=0, `PC_below8bit`=RESET_PC[7:0]. State = FETCH.
- **Reset mid-instruction:** a partially executed instruction is discarded, with no register write and no count.
- **`i_req`** = (state==FETCH) & `cpu_enable` & ~`reset`. It is combinational and asserts the first cycle after reset deasserts. `i_addr` is stable while `i_req`=1.
- **Latency:** 4 cycles per instruction with zero-wait memory, i.e. `i_ready` in the first FETCH cycle. Each wait cycle adds 1.
- **Visibility:** PC, registers, `num_inst`, `output_port` and `wwd_valid` update at the WB edge. The next fetch uses the new PC.
- **Simultaneous events**
  - `reset` beats `cpu_enable`.
  - `cpu_enable`=0 in the same cycle as `i_ready`=1 is ignored: no fetch is accepted.
- **`halted`** rises at the WB edge of HLT. `i_req` stays 0 afterwards.

## Test plan
- **Reference program:** load the 28-word LHI/WWD/ADI/ADD/JMP program with zero-wait memory. Required:
  - WWD sequence 0x0000, 0x0100, 0x0200, 0x0300, 0x0004, 0x00FC, 0x0100, 0x0300, 0x0000, 0x0100, 0x0400, 0x0300.
  - Words 17–20 never fetched.
  - `num_inst`=24 after the last WWD retires; 4 cycles per instruction.
- **Wait states:** `i_ready` delayed 3 cycles per fetch, same program. Identical outputs, 7 cycles per instruction, `i_addr` stable throughout.
- **Branches:**
  - BEQ with equal regs and imm=−2: PC goes 10 → 9.
  - BNE with equal regs: PC goes to 11.
  - BGZ on 0x8000: not taken.
  - BLZ on 0x8000: taken.
- **JAL/JRL/JPR:** JAL 0x050 from PC 3 writes $2=4 and PC=0x050. A following JPR $2 returns to 4.
- **Stall and halt:**
  - Drop `cpu_enable` for 5 cycles mid-EXEC: no state change, `i_req`=0.
  - HLT: `halted`=1, `i_req`=0 forever, `num_inst` includes the HLT.
  - Reset then restarts at RESET_PC.
- **Display mode:** with `wwd_enable`=0 and `register_selection`=3 after LHI $3,0x7F, `output_port`=0x7F00 and WWD produces no `wwd_valid`.
